ulpi_link_core: RTL and testbench

- Link-side ULPI engine between the ULPI PHY pins and the link-facing byte interface (data/data_valid/rx_cmd, cmd/cmd_strobe/cmd_busy).
- Receive path: decodes PHY-owned bus cycles into RX data bytes and RX CMD bytes.
- Transmit path: executes register-write and register-read TX CMD sequences with bus-turnaround handling, RX-priority abort/retry and an nxt timeout.

---
 rtl/ulpi_link_core.sv | 234 +++++++++++++++++++++++
 tb/tb_ulpi_link_core.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_link_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ulpi_link_core                                                |
// | Purpose  : Link-side ULPI engine. Decodes PHY-owned bus cycles into RX   |
// |            data / RX CMD bytes, and runs register-write and register-    |
// |            read TX CMD sequences with turnaround handling, RX-priority  |
// |            abort/retry and an nxt timeout.                               |
// | Ports    : clk, reset_n          - link clock, async active-low reset    |
// |            ulpi_dir/nxt/data_in  - PHY pins in                           |
// |            ulpi_data_out/oe/stp  - PHY pins out                          |
// |            data, data_valid      - received USB byte + 1-cycle strobe    |
// |            rx_cmd                - last RX CMD byte (held)               |
// |            cmd, cmd_strobe       - command / register-data byte input    |
// |            cmd_busy              - 1 = cmd_strobe is ignored             |
// |            reg_rdata(_valid)     - register read result + strobe         |
// |            cmd_error             - strobe on timeout or illegal command  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ulpi_link_core #(
  parameter int unsigned NXT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  output logic [7:0] data,
  output logic       data_valid,
  output logic [7:0] rx_cmd,
  input  logic [7:0] cmd,
  input  logic       cmd_strobe,
  output logic       cmd_busy,
  output logic [7:0] reg_rdata,
  output logic       reg_rdata_valid,
  output logic       cmd_error
);

  localparam logic [5:0] EXT_ADDR = 6'h2F;
  localparam logic [7:0] CNT_LAST = 8'(NXT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WDATA   = 3'd1,
    TXCMD   = 3'd2,
    TXDAT   = 3'd3,
    WSTP    = 3'd4,
    RD_TURN = 3'd5,
    RD_DATA = 3'd6
  } state_t;

  state_t     state;
  logic       dir_q;
  logic [7:0] cmd_q;
  logic [7:0] wdata_q;
  logic [7:0] nxt_cnt;
  logic       phy_owns;
  logic       cmd_accept;
  logic       waiting;
  logic       timeout;

  // PHY owns the bus only once dir has been high for two samples; the
  // first high sample is the turnaround and its data is meaningless.
  assign phy_owns     = ulpi_dir && dir_q;
  assign ulpi_data_oe = !ulpi_dir && !dir_q;
  assign cmd_accept   = cmd_strobe && !cmd_busy;

  // Cycles on which the FSM is stalled waiting for the PHY. Cycles where
  // the PHY has taken the bus (preempt) never count toward the timeout.
  always_comb begin
    waiting = 1'b0;
    case (state)
      TXCMD,
      TXDAT:   waiting = ulpi_data_oe && !ulpi_nxt;
      RD_TURN: waiting = !ulpi_dir;
      RD_DATA: waiting = !ulpi_nxt && !phy_owns;
      default: waiting = 1'b0;
    endcase
  end

  assign timeout = waiting && (nxt_cnt == CNT_LAST);

  // Receive decode: independent of the TX FSM except that the register-read
  // result byte must not be mistaken for an RX CMD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q      <= 1'b1;
      data       <= 8'h00;
      data_valid <= 1'b0;
      rx_cmd     <= 8'h00;
    end else begin
      dir_q      <= ulpi_dir;
      data_valid <= 1'b0;
      if (phy_owns) begin
        if (ulpi_nxt) begin
          data       <= ulpi_data_in;
          data_valid <= 1'b1;
        end else if (state != RD_DATA) begin
          rx_cmd <= ulpi_data_in;
        end
      end
    end
  end

  // Transmit FSM. ulpi_data_out is loaded with the byte for the state being
  // entered, so it is a clean registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cmd_q           <= 8'h00;
      wdata_q         <= 8'h00;
      nxt_cnt         <= 8'h00;
      ulpi_stp        <= 1'b1;
      ulpi_data_out   <= 8'h00;
      cmd_busy        <= 1'b1;
      reg_rdata       <= 8'h00;
      reg_rdata_valid <= 1'b0;
      cmd_error       <= 1'b0;
    end else begin
      ulpi_stp        <= 1'b0;
      reg_rdata_valid <= 1'b0;
      cmd_error       <= 1'b0;

      if (ulpi_nxt) begin
        nxt_cnt <= 8'h00;
      end else if (waiting) begin
        nxt_cnt <= nxt_cnt + 8'd1;
      end

      if (timeout) begin
        state         <= IDLE;
        nxt_cnt       <= 8'h00;
        cmd_error     <= 1'b1;
        ulpi_stp      <= ulpi_data_oe;
        ulpi_data_out <= 8'h00;
        cmd_busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cmd_busy <= 1'b0;
            if (cmd_accept) begin
              case (cmd[7:6])
                2'b10: begin
                  if (cmd[5:0] == EXT_ADDR) begin
                    cmd_error <= 1'b1;
                  end else begin
                    cmd_q <= cmd;
                    state <= WDATA;
                  end
                end
                2'b11: begin
                  if (cmd[5:0] == EXT_ADDR) begin
                    cmd_error <= 1'b1;
                  end else begin
                    cmd_q         <= cmd;
                    state         <= TXCMD;
                    nxt_cnt       <= 8'h00;
                    ulpi_data_out <= cmd;
                    cmd_busy      <= 1'b1;
                  end
                end
                2'b01:   cmd_error <= 1'b1;
                default: ;
              endcase
            end
          end
          WDATA: begin
            if (cmd_accept) begin
              wdata_q       <= cmd;
              state         <= TXCMD;
              nxt_cnt       <= 8'h00;
              ulpi_data_out <= cmd_q;
              cmd_busy      <= 1'b1;
            end
          end
          TXCMD: begin
            if (ulpi_data_oe && ulpi_nxt) begin
              nxt_cnt <= 8'h00;
              // cmd_q[6] separates read (2'b11) from write (2'b10)
              if (cmd_q[6]) begin
                state         <= RD_TURN;
                ulpi_data_out <= 8'h00;
              end else begin
                state         <= TXDAT;
                ulpi_data_out <= wdata_q;
              end
            end
          end
          TXDAT: begin
            if (ulpi_dir) begin
              state         <= TXCMD;
              nxt_cnt       <= 8'h00;
              ulpi_data_out <= cmd_q;
            end else if (ulpi_data_oe && ulpi_nxt) begin
              state         <= WSTP;
              nxt_cnt       <= 8'h00;
              ulpi_stp      <= 1'b1;
              ulpi_data_out <= 8'h00;
            end
          end
          WSTP: begin
            state    <= IDLE;
            cmd_busy <= 1'b0;
          end
          RD_TURN: begin
            if (ulpi_dir && !dir_q) begin
              nxt_cnt <= 8'h00;
              // nxt with the turnaround means RxActive won the bus
              if (ulpi_nxt) begin
                state         <= TXCMD;
                ulpi_data_out <= cmd_q;
              end else begin
                state <= RD_DATA;
              end
            end
          end
          RD_DATA: begin
            if (phy_owns && !ulpi_nxt) begin
              reg_rdata       <= ulpi_data_in;
              reg_rdata_valid <= 1'b1;
              state           <= IDLE;
              cmd_busy        <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ulpi_link_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ulpi_link_core                                             |
// | Purpose  : Self-checking bench for ulpi_link_core. A scripted PHY drives |
// |            RX bursts, register writes/reads, preempts, timeouts and      |
// |            illegal commands; expectations come from the bus protocol    |
// |            rules (cycle counts, byte sequences, tracked rx_cmd).         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ulpi_link_core;

  localparam int TO = 4;

  logic       clk          = 1'b0;
  logic       reset_n      = 1'b0;
  logic       ulpi_dir     = 1'b1;
  logic       ulpi_nxt     = 1'b0;
  logic [7:0] ulpi_data_in = 8'h00;
  logic [7:0] cmd          = 8'h00;
  logic       cmd_strobe   = 1'b0;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe;
  logic       ulpi_stp;
  logic [7:0] data;
  logic       data_valid;
  logic [7:0] rx_cmd;
  logic       cmd_busy;
  logic [7:0] reg_rdata;
  logic       reg_rdata_valid;
  logic       cmd_error;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_rxcmd = 8'h00;
  logic [7:0] fix_b [4];

  ulpi_link_core #(.NXT_TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ulpi_dir       (ulpi_dir),
    .ulpi_nxt       (ulpi_nxt),
    .ulpi_data_in   (ulpi_data_in),
    .ulpi_data_out  (ulpi_data_out),
    .ulpi_data_oe   (ulpi_data_oe),
    .ulpi_stp       (ulpi_stp),
    .data           (data),
    .data_valid     (data_valid),
    .rx_cmd         (rx_cmd),
    .cmd            (cmd),
    .cmd_strobe     (cmd_strobe),
    .cmd_busy       (cmd_busy),
    .reg_rdata      (reg_rdata),
    .reg_rdata_valid(reg_rdata_valid),
    .cmd_error      (cmd_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic d, input logic n, input logic [7:0] b);
    ulpi_dir     = d;
    ulpi_nxt     = n;
    ulpi_data_in = b;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // PHY takes the bus (turnaround with nxt=1), streams n cycles, releases it.
  // nxt=1 cycles are USB data, nxt=0 cycles are RX CMD bytes.
  task automatic rx_burst(input int n, input bit fixed);
    logic [7:0] b;
    logic       nx;
    set(1'b1, 1'b1, 8'($urandom));
    #1;
    chk("rx_oe_drop", ulpi_data_oe, 0);
    tick();
    chk("rx_turn_nostrobe", data_valid, 0);
    for (int i = 0; i < n; i++) begin
      if (fixed) begin
        b  = fix_b[i];
        nx = (i < 3);
      end else begin
        b  = 8'($urandom);
        nx = 1'($urandom % 2);
      end
      set(1'b1, nx, b);
      tick();
      if (nx) begin
        chk("rx_dv", data_valid, 1);
        chk("rx_data", data, b);
      end else begin
        exp_rxcmd = b;
        chk("rx_cmd_dv", data_valid, 0);
        chk("rx_cmd", rx_cmd, exp_rxcmd);
      end
    end
    set(1'b0, 1'b0, 8'h00);
    tick();
    chk("rx_release_dv", data_valid, 0);
    chk("rx_cmd_hold", rx_cmd, exp_rxcmd);
  endtask

  // Link is in TXCMD owning the bus; PHY withholds nxt for d cycles then
  // accepts. Random strobes meanwhile must be ignored (cmd_busy=1).
  task automatic tx_cmd_phase(input logic [7:0] c, input int d);
    for (int i = 0; i <= d; i++) begin
      chk("tx_oe", ulpi_data_oe, 1);
      chk("tx_bus_cmd", ulpi_data_out, c);
      chk("tx_busy", cmd_busy, 1);
      cmd        = 8'($urandom);
      cmd_strobe = 1'($urandom % 2);
      set(1'b0, (i == d), 8'h00);
      tick();
      chk("tx_no_err", cmd_error, 0);
    end
    cmd_strobe = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] c, input logic [7:0] wd,
                          input int d, input int gap, input int pre);
    cmd = c; cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
    chk("wr_busy_wdata", cmd_busy, 0);
    chk("wr_bus_wdata", ulpi_data_out, 8'h00);
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("wr_wdata_noto", cmd_error, 0);
    end
    cmd = wd; cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
    tx_cmd_phase(c, d);
    chk("wr_bus_data", ulpi_data_out, wd);
    if (pre > 0) begin
      rx_burst(pre, 1'b0);
      tx_cmd_phase(c, int'($urandom_range(0, 2)));
      chk("wr_bus_data_retry", ulpi_data_out, wd);
    end
    set(1'b0, 1'b1, 8'h00);
    tick();
    chk("wr_stp", ulpi_stp, 1);
    chk("wr_stp_bus", ulpi_data_out, 8'h00);
    set(1'b0, 1'b0, 8'h00);
    tick();
    chk("wr_stp_once", ulpi_stp, 0);
    chk("wr_done_busy", cmd_busy, 0);
    chk("wr_done_err", cmd_error, 0);
  endtask

  task automatic do_read(input logic [7:0] c, input logic [7:0] rd,
                         input int d, input int w, input int pre);
    cmd = c; cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
    tx_cmd_phase(c, d);
    if (pre > 0) begin
      rx_burst(pre, 1'b0);
      tx_cmd_phase(c, d);
    end
    for (int i = 0; i < w; i++) begin
      chk("rd_turn_bus", ulpi_data_out, 8'h00);
      set(1'b0, 1'b0, 8'h00);
      tick();
    end
    set(1'b1, 1'b0, 8'($urandom));
    #1;
    chk("rd_turn_oe", ulpi_data_oe, 0);
    tick();
    chk("rd_turn_rv", reg_rdata_valid, 0);
    set(1'b1, 1'b0, rd);
    tick();
    chk("rd_rv", reg_rdata_valid, 1);
    chk("rd_data", reg_rdata, rd);
    chk("rd_rxcmd_kept", rx_cmd, exp_rxcmd);
    chk("rd_busy", cmd_busy, 0);
    set(1'b0, 1'b0, 8'h00);
    tick();
    chk("rd_rv_once", reg_rdata_valid, 0);
  endtask

  // phase 0: stall in TXCMD, 1: stall after the command byte was taken
  task automatic do_timeout(input logic [7:0] c, input logic [7:0] wd, input int phase);
    cmd = c; cmd_strobe = 1'b1;
    tick();
    if (!c[6]) begin
      cmd = wd;
      tick();
    end
    cmd_strobe = 1'b0;
    if (phase > 0) tx_cmd_phase(c, 0);
    for (int k = 1; k <= TO; k++) begin
      set(1'b0, 1'b0, 8'h00);
      tick();
      if (k < TO) begin
        chk("to_early", cmd_error, 0);
      end else begin
        chk("to_err", cmd_error, 1);
        chk("to_stp", ulpi_stp, 1);
        chk("to_busy", cmd_busy, 0);
      end
    end
    tick();
    chk("to_err_once", cmd_error, 0);
    chk("to_stp_once", ulpi_stp, 0);
    chk("to_bus_idle", ulpi_data_out, 8'h00);
  endtask

  task automatic do_illegal(input logic [7:0] c, input logic expect_err);
    cmd = c; cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
    chk("ill_err", cmd_error, expect_err);
    chk("ill_busy", cmd_busy, 0);
    chk("ill_bus", ulpi_data_out, 8'h00);
    chk("ill_stp", ulpi_stp, 0);
    tick();
    chk("ill_err_once", cmd_error, 0);
  endtask

  function automatic logic [5:0] rand_addr();
    logic [5:0] a;
    a = 6'($urandom);
    if (a == 6'h2F) a = 6'h00;
    return a;
  endfunction

  initial begin
    fix_b[0] = 8'hC3; fix_b[1] = 8'h11; fix_b[2] = 8'h22; fix_b[3] = 8'h4E;

    // reset values, PHY holding dir high
    tick(); tick();
    chk("rst_stp", ulpi_stp, 1);
    chk("rst_oe", ulpi_data_oe, 0);
    chk("rst_bus", ulpi_data_out, 8'h00);
    chk("rst_busy", cmd_busy, 1);
    chk("rst_dv", data_valid, 0);
    chk("rst_rxcmd", rx_cmd, 8'h00);
    chk("rst_rdata", reg_rdata, 8'h00);
    chk("rst_rv", reg_rdata_valid, 0);
    chk("rst_err", cmd_error, 0);
    reset_n = 1'b1;
    tick();
    chk("rel_stp", ulpi_stp, 0);
    chk("rel_busy", cmd_busy, 0);
    chk("rel_oe_dirhigh", ulpi_data_oe, 0);
    set(1'b0, 1'b0, 8'h00);
    #1;
    chk("rel_oe_dirq", ulpi_data_oe, 0);
    tick();
    chk("rel_oe", ulpi_data_oe, 1);
    chk("rel_bus", ulpi_data_out, 8'h00);

    // directed scenarios
    rx_burst(4, 1'b1);
    do_write(8'h84, 8'h5A, 2, 0, 0);
    do_write(8'h84, 8'h5A, 0, TO + 2, 0);
    do_read(8'hC1, 8'h2B, 0, 0, 0);
    do_write(8'h84, 8'h5A, 1, 0, 3);
    do_read({2'b11, rand_addr()}, 8'($urandom), 1, 2, 2);
    do_timeout({2'b11, rand_addr()}, 8'h00, 0);
    do_timeout({2'b10, rand_addr()}, 8'($urandom), 0);
    do_timeout({2'b10, rand_addr()}, 8'($urandom), 1);
    do_timeout({2'b11, rand_addr()}, 8'h00, 1);
    do_illegal(8'h40, 1'b1);
    do_illegal(8'hAF, 1'b1);
    do_illegal(8'h00, 1'b0);
    do_illegal({2'b01, 6'($urandom)}, 1'b1);

    // reset in the middle of a read: nothing latched survives
    cmd = {2'b11, rand_addr()}; cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
    chk("mr_busy_pre", cmd_busy, 1);
    reset_n = 1'b0;
    exp_rxcmd = 8'h00;
    #1;
    chk("mr_stp", ulpi_stp, 1);
    chk("mr_busy", cmd_busy, 1);
    chk("mr_bus", ulpi_data_out, 8'h00);
    chk("mr_oe", ulpi_data_oe, 0);
    chk("mr_rxcmd", rx_cmd, exp_rxcmd);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mr_rel_stp", ulpi_stp, 0);
    chk("mr_rel_busy", cmd_busy, 0);
    chk("mr_rel_rv", reg_rdata_valid, 0);
    chk("mr_rel_err", cmd_error, 0);
    chk("mr_rel_dv", data_valid, 0);
    tick();
    chk("mr_idle_oe", ulpi_data_oe, 1);
    chk("mr_idle_bus", ulpi_data_out, 8'h00);

    // randomized mix of operations
    for (int r = 0; r < 12; r++) begin
      case ($urandom % 4)
        0: do_write({2'b10, rand_addr()}, 8'($urandom), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        1: do_read({2'b11, rand_addr()}, 8'($urandom), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        2: rx_burst(int'($urandom_range(1, 6)), 1'b0);
        default: do_illegal({2'b01, 6'($urandom)}, 1'b1);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
